// File: rtl/spdif_sample_writer.sv
// S/PDIF sample writer: streams 24-bit samples into a circular RAM ring as two 16-bit
// Wishbone writes. Define SPDIF_WR_OVERRUN_DROP_EN to drop (and count) samples when full.
module spdif_sample_writer #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [23:0]           s_data_i,
  input  logic                  s_chan_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [1:0]            wb_sel_o,
  output logic [31:0]           wb_adr_o,
  output logic [15:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic [ADDR_WIDTH-2:0] rd_ptr_i,
  output logic [ADDR_WIDTH-2:0] wr_ptr_o,
  output logic [ADDR_WIDTH-2:0] level_o,
  output logic                  full_o,
  output logic [15:0]           overrun_cnt_o
);

  localparam int unsigned PtrW = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StWrLo, StWrHi} state_e;

  state_e            state_q, state_d;
  logic [23:0]       data_q, data_d;
  logic              chan_q, chan_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic              full;
  logic              accept;
  logic [31:0]       sample_adr;

  // One slot stays empty so full and empty remain distinguishable.
  assign full     = (wr_ptr_q + PtrW'(1)) == rd_ptr_i;
  assign full_o   = full;
  assign level_o  = wr_ptr_q - rd_ptr_i;
  assign wr_ptr_o = wr_ptr_q;

`ifdef SPDIF_WR_OVERRUN_DROP_EN
  assign s_ready_o = !wb_rst_i && (state_q == StIdle);
`else
  assign s_ready_o = !wb_rst_i && (state_q == StIdle) && !full;
`endif

  assign accept     = s_valid_i && s_ready_o;
  assign sample_adr = BASE_ADDR + (32'(wr_ptr_q) << 2);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    chan_d   = chan_q;
    wr_ptr_d = wr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d = s_data_i;
          chan_d = s_chan_i;
          if (!full) state_d = StWrLo;
        end
      end
      StWrLo: begin
        if (wb_ack_i) state_d = StWrHi;
      end
      StWrHi: begin
        if (wb_ack_i) begin
          wr_ptr_d = wr_ptr_q + PtrW'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs decode purely from registered state, so they hold steady across wait states.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = 2'b00;
    wb_adr_o = 32'h0;
    wb_dat_o = 16'h0;
    if (state_q == StWrLo || state_q == StWrHi) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = 1'b1;
      wb_we_o  = 1'b1;
      wb_sel_o = 2'b11;
    end
    if (state_q == StWrLo) begin
      wb_adr_o = sample_adr;
      wb_dat_o = data_q[15:0];
    end else if (state_q == StWrHi) begin
      wb_adr_o = sample_adr + 32'd2;
      wb_dat_o = {chan_q, 7'b0, data_q[23:16]};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      data_q   <= 24'h0;
      chan_q   <= 1'b0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

`ifdef SPDIF_WR_OVERRUN_DROP_EN
  logic [15:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (accept && full && overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) overrun_q <= 16'h0;
    else          overrun_q <= overrun_d;
  end

  assign overrun_cnt_o = overrun_q;
`else
  assign overrun_cnt_o = 16'h0;
`endif

endmodule
